// File: rtl/sram_read_cache_pkg.sv
// Shared types and constants for the direct-mapped SRAM read cache.
package sram_read_cache_pkg;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      READ_MISS     = 2'd1,
      WRITE_THROUGH = 2'd2
   } state_e;

   // Bit positions of the tag and index fields inside the byte address.
   localparam int TAG_LSB   = 8;
   localparam int INDEX_LSB = 2;

   // Field widths of one stored line.
   localparam int LINE_TAG_W  = 10;
   localparam int LINE_DATA_W = 32;

   typedef struct packed {
      logic                   valid;
      logic [LINE_TAG_W-1:0]  tag;
      logic [LINE_DATA_W-1:0] data;
   } line_t;

endpackage

// File: rtl/sram_read_cache_line_array.sv
// Tag/valid/data storage: asynchronous lookup, one synchronous write port and
// a flash invalidate that clears every valid bit in one edge.
module cache_line_array
   import sram_read_cache_pkg::*;
#(
   parameter int INDEX_BITS = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output line_t                 rd_line_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  line_t                 wr_line_i,
   input  logic                  inv_all_i
);

   localparam int DEPTH = 1 << INDEX_BITS;

   logic [DEPTH-1:0]       valid_q;
   logic [LINE_TAG_W-1:0]  tag_q  [DEPTH];
   logic [LINE_DATA_W-1:0] data_q [DEPTH];

   assign rd_line_o = {valid_q[rd_idx_i], tag_q[rd_idx_i], data_q[rd_idx_i]};

   // Valid bits: cleared by reset and flash invalidate, which wins over a write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (inv_all_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_line_i.valid;
      end
   end

   // Tag and data payload; no reset needed since valid gates every use.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_line_i.tag;
         data_q[wr_idx_i] <= wr_line_i.data;
      end
   end

endmodule

// File: rtl/sram_read_cache.sv
// Direct-mapped, write-through, no-write-allocate cache in front of the SRAM
// controller. Read hits answer in the request cycle; misses and writes hold
// ready low until the controller pulses sram_ready.
module sram_read_cache
   import sram_read_cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 10,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              flush,
   output logic [DATA_W-1:0] read_data,
   output logic              ready,
   output logic              sram_rd_en,
   output logic              sram_wr_en,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_write_data,
   input  logic [DATA_W-1:0] sram_read_data,
   input  logic              sram_ready,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e              state_q;
   logic [ADDR_W-1:0]   req_addr_q;
   logic [DATA_W-1:0]   req_data_q;
   logic                sram_rd_en_q;
   logic                sram_wr_en_q;
   logic                flush_pend_q;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   logic [INDEX_BITS-1:0] idx, req_idx, arr_widx;
   logic [TAG_BITS-1:0]   tag, req_tag;
   line_t                 rd_line, wr_line;
   logic                  arr_we, inv_all;
   logic                  rd_req, wr_req, lookup_hit, rd_hit, rd_miss;
   logic                  unused_addr;

   assign idx     = address[INDEX_LSB +: INDEX_BITS];
   assign tag     = address[TAG_LSB +: TAG_BITS];
   assign req_idx = req_addr_q[INDEX_LSB +: INDEX_BITS];
   assign req_tag = req_addr_q[TAG_LSB +: TAG_BITS];

   assign unused_addr = ^{address[ADDR_W-1:TAG_LSB+TAG_BITS], address[INDEX_LSB-1:0]};

   // Simultaneous rd_en and wr_en is resolved as a write.
   assign wr_req = wr_en;
   assign rd_req = rd_en & ~wr_en;

   // A flush left pending from the last transaction already makes every line
   // stale, so the first IDLE cycle must not report a hit either.
   assign lookup_hit = rd_line.valid && (rd_line.tag == tag) && !flush_pend_q;
   assign rd_hit     = (state_q == IDLE) && rd_req && lookup_hit;
   assign rd_miss    = (state_q == IDLE) && rd_req && !lookup_hit;
   assign inv_all    = (state_q == IDLE) && (flush || flush_pend_q);

   cache_line_array #(
      .INDEX_BITS (INDEX_BITS)
   ) u_lines (
      .clk_i     (clk),
      .rst_ni    (rst),
      .rd_idx_i  (idx),
      .rd_line_o (rd_line),
      .wr_en_i   (arr_we),
      .wr_idx_i  (arr_widx),
      .wr_line_i (wr_line),
      .inv_all_i (inv_all)
   );

   // Line write source: store hit updates data in place, miss completion fills.
   always_comb begin
      arr_we   = 1'b0;
      arr_widx = idx;
      wr_line  = '{valid: 1'b1, tag: tag, data: write_data};
      if ((state_q == IDLE) && wr_req && lookup_hit) begin
         arr_we = 1'b1;
      end else if ((state_q == READ_MISS) && sram_ready) begin
         arr_we   = 1'b1;
         arr_widx = req_idx;
         wr_line  = '{valid: 1'b1, tag: req_tag, data: sram_read_data};
      end
   end

   // Pipeline handshake and load result; forced idle-looking while in reset.
   always_comb begin
      ready     = 1'b1;
      read_data = '0;
      if (rst) begin
         unique case (state_q)
            IDLE: begin
               ready = !(rd_en || wr_en) || rd_hit;
               if (rd_hit) read_data = rd_line.data;
            end
            READ_MISS: begin
               ready = sram_ready;
               if (sram_ready) read_data = sram_read_data;
            end
            WRITE_THROUGH: ready = sram_ready;
            default:       ready = 1'b1;
         endcase
      end
   end

   // Saturating performance counters; stores are never counted.
   always_comb begin
      hit_cnt_d  = rd_hit  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
      miss_cnt_d = rd_miss ? sat_inc(miss_cnt_q) : miss_cnt_q;
   end

   // Controller FSM with registered SRAM request outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         req_addr_q   <= '0;
         req_data_q   <= '0;
         sram_rd_en_q <= 1'b0;
         sram_wr_en_q <= 1'b0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         unique case (state_q)
            IDLE: begin
               flush_pend_q <= 1'b0;
               if (wr_req) begin
                  state_q      <= WRITE_THROUGH;
                  req_addr_q   <= address;
                  req_data_q   <= write_data;
                  sram_wr_en_q <= 1'b1;
               end else if (rd_miss) begin
                  state_q      <= READ_MISS;
                  req_addr_q   <= address;
                  sram_rd_en_q <= 1'b1;
               end
            end
            READ_MISS: begin
               if (flush) flush_pend_q <= 1'b1;
               if (sram_ready) begin
                  state_q      <= IDLE;
                  sram_rd_en_q <= 1'b0;
               end
            end
            WRITE_THROUGH: begin
               if (flush) flush_pend_q <= 1'b1;
               if (sram_ready) begin
                  state_q      <= IDLE;
                  sram_wr_en_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sram_rd_en      = sram_rd_en_q;
   assign sram_wr_en      = sram_wr_en_q;
   assign sram_address    = req_addr_q;
   assign sram_write_data = req_data_q;
   assign hit_count       = hit_cnt_q;
   assign miss_count      = miss_cnt_q;

endmodule

// File: tb/tb_sram_read_cache.sv
// Directed bench for sram_read_cache with a reference cache/memory model and
// a queue of expected load results.
`timescale 1ns/1ps
module tb_sram_read_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en, flush, sram_ready;
   logic [31:0] address, write_data, sram_read_data;
   logic [31:0] read_data, sram_address, sram_write_data;
   logic        ready, sram_rd_en, sram_wr_en;
   logic [15:0] hit_count, miss_count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   bit          mvalid [64];
   logic [9:0]  mtag   [64];
   logic [31:0] mdata  [64];
   logic [31:0] mem    [logic [31:0]];
   int          exp_hits = 0;
   int          exp_miss = 0;

   sram_read_cache dut (
      .clk             (clk),
      .rst             (rst),
      .rd_en           (rd_en),
      .wr_en           (wr_en),
      .address         (address),
      .write_data      (write_data),
      .flush           (flush),
      .read_data       (read_data),
      .ready           (ready),
      .sram_rd_en      (sram_rd_en),
      .sram_wr_en      (sram_wr_en),
      .sram_address    (sram_address),
      .sram_write_data (sram_write_data),
      .sram_read_data  (sram_read_data),
      .sram_ready      (sram_ready),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memval(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return mem.exists(w) ? mem[w] : (w ^ 32'h5A5A_0000);
   endfunction

   function automatic void model_flush();
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
   endfunction

   // mode 0: plain read, 1: flush during the miss, 2: flush in the request cycle
   task automatic do_read(input logic [31:0] a, input int mode);
      int          idx;
      logic [9:0]  t;
      bit          hit;
      logic [31:0] d;
      idx = int'(a[7:2]);
      t   = a[17:8];
      hit = mvalid[idx] && (mtag[idx] == t);
      d   = hit ? mdata[idx] : memval(a);
      @(negedge clk);
      rd_en   = 1'b1;
      address = a;
      flush   = (mode == 2);
      exp_q.push_back(d);
      #1;
      chk("rd_ready_first", {31'd0, ready}, {31'd0, hit});
      if (hit) begin
         chk("rd_hit_data", read_data, exp_q.pop_front());
         chk("rd_hit_no_sram", {31'd0, sram_rd_en}, 32'd0);
         if (exp_hits < 65535) exp_hits++;
         @(negedge clk);
         rd_en = 1'b0;
         flush = 1'b0;
         if (mode == 2) model_flush();
      end else begin
         if (exp_miss < 65535) exp_miss++;
         @(negedge clk);
         flush = (mode == 1);
         #1;
         chk("miss_sram_rd_en", {31'd0, sram_rd_en}, 32'd1);
         chk("miss_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
         chk("miss_sram_addr", sram_address, a);
         chk("miss_ready_low", {31'd0, ready}, 32'd0);
         repeat (4) begin
            @(negedge clk);
            flush = 1'b0;
         end
         sram_ready     = 1'b1;
         sram_read_data = memval(a);
         #1;
         chk("miss_done_ready", {31'd0, ready}, 32'd1);
         chk("miss_done_data", read_data, exp_q.pop_front());
         mvalid[idx] = 1'b1;
         mtag[idx]   = t;
         mdata[idx]  = memval(a);
         if (mode == 1) model_flush();
         @(negedge clk);
         sram_ready = 1'b0;
         rd_en      = 1'b0;
         #1;
         chk("miss_rd_en_drop", {31'd0, sram_rd_en}, 32'd0);
      end
      chk("miss_count", {16'd0, miss_count}, exp_miss);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      int         idx;
      logic [9:0] t;
      idx = int'(a[7:2]);
      t   = a[17:8];
      @(negedge clk);
      wr_en      = 1'b1;
      address    = a;
      write_data = d;
      #1;
      chk("wr_ready_low", {31'd0, ready}, 32'd0);
      if (mvalid[idx] && (mtag[idx] == t)) mdata[idx] = d;
      mem[{a[31:2], 2'b00}] = d;
      @(negedge clk);
      #1;
      chk("wt_sram_wr_en", {31'd0, sram_wr_en}, 32'd1);
      chk("wt_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
      chk("wt_sram_addr", sram_address, a);
      chk("wt_sram_data", sram_write_data, d);
      repeat (2) @(negedge clk);
      sram_ready = 1'b1;
      #1;
      chk("wt_done_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      sram_ready = 1'b0;
      wr_en      = 1'b0;
      #1;
      chk("wt_wr_en_drop", {31'd0, sram_wr_en}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0; sram_ready = 1'b0;
      address = '0; write_data = '0; sram_read_data = '0;
      model_flush();
      mem[32'h104] = 32'hDEADBEEF;
      mem[32'h204] = 32'hCAFEF00D;
      mem[32'h308] = 32'h0BAD_F00D;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
      chk("rst_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
      chk("rst_sram_addr", sram_address, 32'd0);
      chk("rst_sram_wdata", sram_write_data, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_hits", {16'd0, hit_count}, 32'd0);
      chk("rst_misses", {16'd0, miss_count}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // cold miss, then the repeated read hits
      do_read(32'h0000_0104, 0);
      do_read(32'h0000_0104, 0);
      chk("hit_count_one", {16'd0, hit_count}, 32'd1);

      // store hit, then the load sees the new data without SRAM access
      do_write(32'h0000_0104, 32'h1234_5678);
      do_read(32'h0000_0104, 0);

      // conflicting tag on index 1 evicts, original address misses again
      do_read(32'h0000_0204, 0);
      do_read(32'h0000_0104, 0);

      // flush during a miss: fill happens, then the line is dropped
      do_read(32'h0000_0308, 1);
      do_read(32'h0000_0308, 0);

      // store miss does not allocate
      do_write(32'h0000_040C, 32'h0000_0055);
      do_read(32'h0000_040C, 0);

      // flush in IDLE alongside a hit uses pre-flush contents
      do_read(32'h0000_040C, 2);
      do_read(32'h0000_040C, 0);
      chk("hit_count_mid", {16'd0, hit_count}, exp_hits);

      // long run of hits saturates the hit counter
      @(negedge clk);
      rd_en   = 1'b1;
      address = 32'h0000_040C;
      exp_q.push_back(mdata[3]);
      repeat (70000) @(negedge clk);
      #1;
      chk("sat_ready", {31'd0, ready}, 32'd1);
      chk("sat_data", read_data, exp_q.pop_front());
      exp_hits = (exp_hits + 70000 > 65535) ? 65535 : exp_hits + 70000;
      chk("hit_saturated", {16'd0, hit_count}, exp_hits);
      chk("miss_unchanged", {16'd0, miss_count}, exp_miss);
      @(negedge clk);
      rd_en = 1'b0;

      // reset in the middle of a write-through abandons it
      @(negedge clk);
      wr_en      = 1'b1;
      address    = 32'h0000_0104;
      write_data = 32'hFFFF_0000;
      @(negedge clk);
      #1;
      chk("pre_rst_wr_en", {31'd0, sram_wr_en}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid_wr_en", {31'd0, sram_wr_en}, 32'd0);
      chk("rst_mid_ready", {31'd0, ready}, 32'd1);
      chk("rst_mid_hits", {16'd0, hit_count}, 32'd0);
      chk("rst_mid_misses", {16'd0, miss_count}, 32'd0);
      chk("rst_mid_rdata", read_data, 32'd0);
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_flush();
      exp_hits = 0;
      exp_miss = 0;

      // every line was invalidated: previously cached address misses
      do_read(32'h0000_0104, 0);
      do_read(32'h0000_0104, 0);
      chk("post_rst_hits", {16'd0, hit_count}, 32'd1);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_read_cache.md
Name: sram_read_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache between the MEM stage and the SRAM controller.
- Presents the same request/ready interface the MEM stage already drives towards the SRAM controller, and drives the controller's request side itself.
- Read hits complete in zero wait cycles; misses and writes stall the pipeline through `ready` until the SRAM controller reports completion.
- Also keeps saturating hit/miss counters for performance debug.

Parameters:
- ADDR_W, 32, width of the byte address from the MEM stage.
- DATA_W, 32, data word width.
- INDEX_BITS, 6, line index width; 64 one-word lines.
- TAG_BITS, 10, tag width; tag = address[17:8], index = address[7:2], address[1:0] ignored.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- rd_en  in  1  load request from MEM stage
- wr_en  in  1  store request from MEM stage
- address  in  ADDR_W  mapped byte address
- write_data  in  DATA_W  store data
- flush  in  1  invalidate all lines
- read_data  out  DATA_W  load result
- ready  out  1  request complete; 0 = freeze pipeline
- sram_rd_en  out  1  read request to SRAM controller
- sram_wr_en  out  1  write request to SRAM controller
- sram_address  out  ADDR_W  address to SRAM controller
- sram_write_data  out  DATA_W  data to SRAM controller
- sram_read_data  in  DATA_W  data from SRAM controller
- sram_ready  in  1  SRAM controller completion pulse
- hit_count  out  CNT_W  read hits, saturating
- miss_count  out  CNT_W  read misses, saturating

Behaviour:
- Reset (rst=0, async):
  - all valid bits cleared; state IDLE.
  - Outputs: ready=1, sram_rd_en=0, sram_wr_en=0, sram_address=0, sram_write_data=0, read_data=0, hit_count=0, miss_count=0.
  - Reset mid-miss or mid-write abandons the transaction; no line is filled.
- State IDLE:
  - No request: ready=1; read_data=0; no SRAM request.
  - Read hit (valid[index] && tag match): read_data = line data combinationally; ready=1 the same cycle; hit_count+1. Stay IDLE.
  - Read miss: ready=0. Latch address into req_addr. Go to READ_MISS; miss_count+1 once per miss.
  - Write: ready=0. Latch address and write_data. If hit, update line data at the clock edge; tag and valid are unchanged. If miss, the line is untouched. Go to WRITE_THROUGH.
  - rd_en and wr_en both high is illegal upstream; it is treated as a write.
- State READ_MISS:
  - sram_rd_en=1 and sram_address=req_addr, held until sram_ready.
  - Cycle with sram_ready=1: read_data=sram_read_data; ready=1; line gets data, tag and valid=1 at the edge; return to IDLE.
- State WRITE_THROUGH:
  - sram_wr_en=1, sram_address=req_addr, sram_write_data=latched data, held until sram_ready.
  - Cycle with sram_ready=1: ready=1; return to IDLE.
- Upstream holds rd_en, wr_en, address and write_data stable while ready=0. The block uses only latched values after entry.
- After returning to IDLE, a request still present is re-evaluated as new. A repeated read then hits.
- Flush:
  - In IDLE, clears all valid bits at the edge; a read in that same cycle still uses the pre-flush contents.
  - A flush asserted in READ_MISS or WRITE_THROUGH is recorded and applied on the first IDLE cycle.
  - A flush recorded during a miss clears the line just filled, so the next read of that address misses.
- Counters saturate at all-ones and never wrap; writes are not counted.
- sram_rd_en and sram_wr_en are never high together and are registered, with no combinational path from rd_en or wr_en.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, READ_MISS=1, WRITE_THROUGH=2);
  - TAG_LSB=8 and INDEX_LSB=2 constants;
  - a line-struct typedef (valid, tag, data).
- One sub-module, cache_line_array:
  - 64-entry tag/valid/data storage;
  - async read port, one sync write port, flash-invalidate input.
- Controller FSM and counters stay in the top.

Test Plan:
- Reset, then rd_en with address=0x0000_0104: ready=0 and sram_rd_en=1 with sram_address=0x104. The bench returns sram_ready and 0xDEADBEEF after 5 cycles; read_data=0xDEADBEEF with ready=1 in that cycle; miss_count=1.
- Same read repeated: ready=1 in the same cycle, read_data=0xDEADBEEF, no SRAM request, hit_count=1.
- Write 0x12345678 to 0x104 (hit): sram_wr_en held until sram_ready, then ready=1. A following read returns 0x12345678 with no SRAM access.
- Read 0x204 (same index 1, tag 2): miss, line replaced with SRAM data. A read of 0x104 afterwards misses again.
- Assert flush during a READ_MISS: the line is filled, then invalidated on the first IDLE edge; a re-read of the same address misses.
- Issue 70000 read hits: hit_count saturates at 0xFFFF. Assert rst mid-WRITE_THROUGH: sram_wr_en=0 and ready=1 immediately, counters=0, all lines invalid.
